mod_addr_gen: RTL

- Upstream address generator for the waveform ROM: an NCO phase accumulator that drives the ROM's 11-bit address each clock.
- Consumes a serial data-bit stream through a valid/ready handshake, one bit per symbol.
- Applies the selected modulation (carrier only, ASK, FSK, BPSK) by steering frequency word, phase and the amplitude-enable flag.
- The ROM registers addr, so downstream sample latency is owned by the ROM.

---
 rtl/mod_addr_gen_if.sv | 23 ++
 rtl/mod_addr_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mod_addr_gen_if.sv
// Bit-stream handshake and ROM-side outputs of the NCO address generator.
// The generator is the slave. The bit source and the ROM/DAC path are the master.
interface mod_addr_gen_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  bit_in;
  logic                  bit_valid;
  logic                  bit_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  amp_en;
  logic                  sym_strobe;
  logic                  underrun;

  modport master (
    output bit_in, bit_valid,
    input  bit_ready, addr, amp_en, sym_strobe, underrun
  );

  modport slave (
    input  bit_in, bit_valid,
    output bit_ready, addr, amp_en, sym_strobe, underrun
  );
endinterface

// File: rtl/mod_addr_gen.sv
// NCO phase accumulator that produces the waveform ROM address each clock.
// It applies carrier/ASK/FSK/BPSK keying from a handshaked serial bit stream.
module mod_addr_gen #(
  parameter int ADDR_WIDTH = 11,
  parameter int ACC_WIDTH  = 24,
  parameter int SLEN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mod_sel,
  input  logic [ACC_WIDTH-1:0]  fcw0,
  input  logic [ACC_WIDTH-1:0]  fcw1,
  input  logic [SLEN_WIDTH-1:0] sym_len,
  mod_addr_gen_if.slave         bus
);

  localparam logic [1:0] MOD_CAR  = 2'b00;
  localparam logic [1:0] MOD_ASK  = 2'b01;
  localparam logic [1:0] MOD_FSK  = 2'b10;
  localparam logic [1:0] MOD_BPSK = 2'b11;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [SLEN_WIDTH-1:0] LEN_ONE  = SLEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] MSB_MASK = {1'b1, {(ADDR_WIDTH-1){1'b0}}};

  logic [0:0]            state;
  logic [ACC_WIDTH-1:0]  acc;
  logic [SLEN_WIDTH-1:0] cnt;
  logic [SLEN_WIDTH-1:0] len_l;
  logic [1:0]            mod_l;
  logic                  cur_bit;
  logic                  nxt_bit;
  logic                  nxt_valid;
  logic                  sym_strobe_q;
  logic                  underrun_q;

  logic [ACC_WIDTH-1:0]  fcw_sel;
  logic [ACC_WIDTH-1:0]  acc_sum;
  logic [SLEN_WIDTH-1:0] len_eff;
  logic                  boundary;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic                  amp_c;

  // NOTE: every signal driven in always_comb is given a default first.
  // A path that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    fcw_sel  = fcw0;
    if (mod_l == MOD_FSK && cur_bit)
      fcw_sel = fcw1;
    acc_sum  = acc + fcw_sel;
    len_eff  = (sym_len == '0) ? LEN_ONE : sym_len;
    boundary = (cnt == len_l - LEN_ONE);
    accept   = bus.bit_valid & ~nxt_valid;

    addr_c = '0;
    amp_c  = 1'b0;
    if (state == S_RUN) begin
      addr_c = acc[ACC_WIDTH-1 -: ADDR_WIDTH];
      // BPSK: inverting the address MSB is a half-period (180 degree) shift.
      if (mod_l == MOD_BPSK && cur_bit)
        addr_c = addr_c ^ MSB_MASK;
      amp_c = (mod_l == MOD_ASK) ? cur_bit : 1'b1;
    end
  end

  assign bus.bit_ready  = ~nxt_valid;
  assign bus.addr       = addr_c;
  assign bus.amp_en     = amp_c;
  assign bus.sym_strobe = sym_strobe_q;
  assign bus.underrun   = underrun_q;

  // NOTE: state registers use non-blocking assignments only.
  // All branches then read the pre-edge values, whatever their order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      acc          <= '0;
      cnt          <= '0;
      len_l        <= '0;
      mod_l        <= MOD_CAR;
      cur_bit      <= 1'b0;
      nxt_bit      <= 1'b0;
      nxt_valid    <= 1'b0;
      sym_strobe_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      sym_strobe_q <= 1'b0;
      underrun_q   <= 1'b0;

      // The handshake ignores en. A bit can only be accepted while the buffer is empty.
      // A bit can only be consumed while the buffer is full, so the two never meet.
      if (accept) begin
        nxt_valid <= 1'b1;
        nxt_bit   <= bus.bit_in;
      end

      if (en) begin
        case (state)
          S_IDLE: begin
            if (nxt_valid) begin
              state        <= S_RUN;
              cur_bit      <= nxt_bit;
              nxt_valid    <= 1'b0;
              acc          <= '0;
              cnt          <= '0;
              mod_l        <= mod_sel;
              len_l        <= len_eff;
              sym_strobe_q <= 1'b1;
            end
          end

          S_RUN: begin
            // The accumulator keeps running across symbol boundaries, so phase stays continuous.
            acc <= acc_sum;
            if (!boundary) begin
              cnt <= cnt + LEN_ONE;
            end else if (nxt_valid) begin
              cur_bit      <= nxt_bit;
              nxt_valid    <= 1'b0;
              cnt          <= '0;
              mod_l        <= mod_sel;
              len_l        <= len_eff;
              sym_strobe_q <= 1'b1;
            end else begin
              state      <= S_IDLE;
              cnt        <= '0;
              underrun_q <= 1'b1;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
